sr_latch_driver: RTL and testbench

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

---
 rtl/sr_latch_driver.sv | 105 ++++++++++
 tb/tb_sr_latch_driver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Sequences a single write into an external SR latch: set up S/R, pulse En,
// let the latch settle, then compare the read-back Q against the target.
module sr_latch_driver #(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_value,
    output logic       req_ready,
    input  logic       q_in,
    output logic       En,
    output logic       S,
    output logic       R,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] fail_count
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t     state_q;
    logic       target_q;
    logic       err_q;
    logic [7:0] cnt_q;
    logic [7:0] fail_q;
    logic [7:0] fail_d;
    logic       drive;

    assign fail_d = sat_inc(fail_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
            fail_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        target_q <= req_value;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    cnt_q   <= PULSE_LOAD;
                    state_q <= PULSE;
                end
                PULSE: begin
                    if (cnt_q == 8'd0) begin
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= SETTLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                SETTLE: begin
                    // Q is sampled at the edge that closes the last settle cycle
                    if (cnt_q == 8'd0) begin
                        err_q   <= q_in ^ target_q;
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                CHECK: begin
                    if (err_q) begin
                        fail_q <= fail_d;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so reset clears them without waiting for a clock
    assign drive      = (state_q == SETUP) || (state_q == PULSE);
    assign S          = drive & target_q;
    assign R          = drive & ~target_q;
    assign En         = (state_q == PULSE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == CHECK);
    assign error      = done & err_q;
    assign req_ready  = (state_q == IDLE) & ~rst;
    assign fail_count = fail_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver: default-parameter instance with a latch
// model on Q, plus a PULSE=1/SETTLE=3 instance used for saturation.
module tb_sr_latch_driver;
    localparam int P1 = 2, S1 = 1, P2 = 1, S2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    typedef struct {
        int at;
        int err;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];

    // default instance
    logic       rst, req_valid, req_value, q_in;
    logic       req_ready, En, S, R, busy, done, error;
    logic [7:0] fail_count;
    logic       latch_m   = 1'b0;
    logic       stuck_en  = 1'b0;
    logic       stuck_val = 1'b0;

    always @(posedge clk) if (En) latch_m <= S ? 1'b1 : (R ? 1'b0 : latch_m);
    assign q_in = stuck_en ? stuck_val : latch_m;

    sr_latch_driver #(.PULSE_CYCLES(P1), .SETTLE_CYCLES(S1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_value(req_value),
        .req_ready(req_ready), .q_in(q_in), .En(En), .S(S), .R(R), .busy(busy),
        .done(done), .error(error), .fail_count(fail_count)
    );

    // short-pulse instance
    logic       rst2, rv2, val2, q_in2;
    logic       rdy2, en2, s2, r2, busy2, done2, err2;
    logic [7:0] fc2;

    sr_latch_driver #(.PULSE_CYCLES(P2), .SETTLE_CYCLES(S2)) dut2 (
        .clk(clk), .rst(rst2), .req_valid(rv2), .req_value(val2),
        .req_ready(rdy2), .q_in(q_in2), .En(en2), .S(s2), .R(r2), .busy(busy2),
        .done(done2), .error(err2), .fail_count(fc2)
    );

    int   en_run1 = 0, en_len1 = 0, en_run2 = 0, en_len2 = 0;
    exp_t e1, e2;

    always @(negedge clk) begin
        check("s_r_excl", int'(S & R), 0);
        check("en_onehot", int'(En & ~(S ^ R)), 0);
        check("err_no_done", int'(error & ~done), 0);
        check("busy_ready", int'(busy ^ req_ready), int'(!rst));
        if (En) en_run1++;
        else if (en_run1 > 0) begin en_len1 = en_run1; en_run1 = 0; end
        if (rst) en_run1 = 0;
        if (done) begin
            if (q1.size() == 0) check("spurious_done", 1, 0);
            else begin
                e1 = q1.pop_front();
                check("done_lat", cyc, e1.at);
                check("done_err", int'(error), e1.err);
            end
        end
        if (req_valid && req_ready && !rst)
            q1.push_back('{cyc + 1 + P1 + S1 + 1, stuck_en ? int'(stuck_val != req_value) : 0});
    end

    always @(negedge clk) begin
        check("s_r_excl2", int'(s2 & r2), 0);
        check("en_onehot2", int'(en2 & ~(s2 ^ r2)), 0);
        check("busy_ready2", int'(busy2 ^ rdy2), int'(!rst2));
        if (en2) en_run2++;
        else if (en_run2 > 0) begin en_len2 = en_run2; en_run2 = 0; end
        if (done2) begin
            if (q2.size() == 0) check("spurious_done2", 1, 0);
            else begin
                e2 = q2.pop_front();
                check("done_lat2", cyc, e2.at);
                check("done_err2", int'(err2), e2.err);
            end
        end
        if (rv2 && rdy2 && !rst2)
            q2.push_back('{cyc + 1 + P2 + S2 + 1, int'(q_in2 != val2)});
    end

    task automatic wait_ready1();
        for (int i = 0; i < 40; i++) begin
            if (req_ready) return;
            @(posedge clk); #1;
        end
        check("timeout1", 0, 1);
    endtask

    task automatic wait_ready2();
        for (int i = 0; i < 40; i++) begin
            if (rdy2) return;
            @(posedge clk); #1;
        end
        check("timeout2", 0, 1);
    endtask

    task automatic write1(input logic v, output int acc);
        wait_ready1();
        req_valid = 1'b1;
        req_value = v;
        @(posedge clk); #1;
        acc       = cyc;
        req_valid = 1'b0;
    endtask

    task automatic write2(input logic v);
        wait_ready2();
        rv2  = 1'b1;
        val2 = v;
        @(posedge clk); #1;
        rv2  = 1'b0;
        wait_ready2();
    endtask

    initial begin
        int   acc;
        int   accs[3];
        logic vals[3];
        vals = '{1'b1, 1'b0, 1'b1};
        rst = 1'b1; rst2 = 1'b1;
        req_valid = 1'b0; req_value = 1'b0;
        rv2 = 1'b0; val2 = 1'b0; q_in2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", int'(req_ready), 0);
        check("rst_en", int'(En), 0);
        check("rst_s", int'(S), 0);
        check("rst_r", int'(R), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fail", int'(fail_count), 0);
        rst = 1'b0; rst2 = 1'b0;
        #1 check("ready_after_rst", int'(req_ready), 1);

        // set write, latch model on Q
        write1(1'b1, acc);
        check("setup_s", int'(S), 1);
        check("setup_r", int'(R), 0);
        check("setup_en", int'(En), 0);
        @(posedge clk); #1;
        check("pulse_en", int'(En), 1);
        wait_ready1();
        check("set_en_len", en_len1, P1);
        check("set_q", int'(q_in), 1);
        check("set_fail", int'(fail_count), 0);

        // reset write with Q stuck at 1
        stuck_en = 1'b1; stuck_val = 1'b1;
        write1(1'b0, acc);
        check("rw_setup_r", int'(R), 1);
        @(posedge clk); #1;
        check("rw_pulse_en", int'(En), 1);
        check("rw_pulse_r", int'(R), 1);
        check("rw_pulse_s", int'(S), 0);
        wait_ready1();
        check("rw_fail", int'(fail_count), 1);

        // back-to-back 1,0,1 with req_valid held high
        stuck_en  = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_value = vals[i];
            wait_ready1();
            @(posedge clk); #1;
            accs[i] = cyc;
            if (i > 0) check("b2b_gap", accs[i] - accs[i-1], P1 + S1 + 3);
        end
        req_valid = 1'b0;
        wait_ready1();
        check("b2b_q", int'(latch_m), 1);

        // inputs toggled while busy must not disturb the write
        stuck_en = 1'b1; stuck_val = 1'b1;
        write1(1'b1, acc);
        for (int k = 1; k <= 4; k++) begin
            if (k <= 3) begin
                check("tog_s", int'(S), 1);
                check("tog_r", int'(R), 0);
            end else begin
                check("tog_settle_s", int'(S), 0);
            end
            req_value = k[0];
            req_valid = (k < 4);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        wait_ready1();
        check("tog_fail", int'(fail_count), 1);

        // reset during PULSE aborts the write
        stuck_en = 1'b0;
        write1(1'b1, acc);
        @(posedge clk); #1;
        check("pre_rst_en", int'(En), 1);
        #1 rst = 1'b1;
        #1;
        check("async_en", int'(En), 0);
        check("async_s", int'(S), 0);
        check("async_r", int'(R), 0);
        check("async_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        check("abort_fail", int'(fail_count), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", int'(req_ready), 1);
        repeat (8) @(posedge clk);
        #1;
        check("abort_pending", q1.size(), 1);
        q1.delete();
        write1(1'b0, acc);
        check("post_abort_busy", int'(busy), 1);
        wait_ready1();
        check("post_abort_fail", int'(fail_count), 0);

        // short pulse, long settle, then saturation
        write2(1'b1);
        check("d2_en_len", en_len2, P2);
        check("d2_fail0", int'(fc2), 0);
        for (int n = 0; n < 256; n++) begin
            write2(1'b0);
            if (n == 0)   check("d2_fail1", int'(fc2), 1);
            if (n == 254) check("d2_fail255", int'(fc2), 255);
        end
        check("d2_fail_sat", int'(fc2), 255);

        repeat (3) @(posedge clk);
        #1;
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
